// File: rtl/std_div_feeder.sv
// std_div_feeder: request FIFO in front of a multi-cycle unsigned divider.
// Zero divisors are resolved locally without calling the divider. Results
// pass through a single-entry output buffer, in request order.
module std_div_feeder #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_left,
  input  logic [WIDTH-1:0] in_right,
  output logic             div_go,
  output logic [WIDTH-1:0] div_left,
  output logic [WIDTH-1:0] div_right,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_by_zero
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] left_mem  [DEPTH];
  logic [WIDTH-1:0] right_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop, head_zero, load_zero, load_div;
  logic [WIDTH-1:0] head_left, head_right;

  // A full FIFO refuses even when a pop happens in the same cycle.
  assign in_ready   = (count != FULL_CNT);
  assign push       = in_valid && in_ready;
  assign head_left  = left_mem[rd_ptr];
  assign head_right = right_mem[rd_ptr];
  assign head_zero  = (head_right == '0);
  // Only pop when the result buffer is free or being drained this cycle.
  assign pop        = (state == IDLE) && (count != '0) && (!out_valid || out_ready);
  assign load_zero  = pop && head_zero;
  assign load_div   = (state == ISSUE) && div_done;

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      left_mem[wr_ptr]  <= in_left;
      right_mem[wr_ptr] <= in_right;
    end
  end

  // FIFO pointers (power-of-two depth wraps naturally) and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Divider handshake FSM: operands latched on pop, go held until done,
  // then one low cycle in RELEASE so the divider can clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      div_go    <= 1'b0;
      div_left  <= '0;
      div_right <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop && !head_zero) begin
            state     <= ISSUE;
            div_go    <= 1'b1;
            div_left  <= head_left;
            div_right <= head_right;
          end
        end
        ISSUE: begin
          if (div_done) begin
            state  <= RELEASE;
            div_go <= 1'b0;
          end
        end
        RELEASE: state <= IDLE;
        default: begin
          state  <= IDLE;
          div_go <= 1'b0;
        end
      endcase
    end
  end

  // Single-entry result buffer; a load wins over a same-cycle consume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid       <= 1'b0;
      out_quotient    <= '0;
      out_remainder   <= '0;
      out_div_by_zero <= 1'b0;
    end else if (load_zero) begin
      out_valid       <= 1'b1;
      out_quotient    <= '1;
      out_remainder   <= head_left;
      out_div_by_zero <= 1'b1;
    end else if (load_div) begin
      out_valid       <= 1'b1;
      out_quotient    <= div_quotient;
      out_remainder   <= div_remainder;
      out_div_by_zero <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_std_div_feeder.sv
// Bench for std_div_feeder: directed scenarios plus randomized traffic,
// with a divider responder and a queue-based result model.
module tb_std_div_feeder;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_left = '0, in_right = '0;
  logic             div_go;
  logic [WIDTH-1:0] div_left, div_right;
  logic             div_done = 1'b0;
  logic [WIDTH-1:0] div_quotient = '0, div_remainder = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_quotient, out_remainder;
  logic             out_div_by_zero;

  std_div_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
    .div_go(div_go), .div_left(div_left), .div_right(div_right),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .out_valid(out_valid), .out_ready(out_ready), .out_quotient(out_quotient),
    .out_remainder(out_remainder), .out_div_by_zero(out_div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             z;
  } res_t;

  int checks = 0;
  int passes = 0;
  res_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    res_t x;
    if (r == '0) begin
      x.q = '1; x.r = l; x.z = 1'b1;
    end else begin
      x.q = l / r; x.r = l % r; x.z = 1'b0;
    end
    return x;
  endfunction

  // Divider responder: answers lat cycles after go rises, once per go;
  // while go is low it may emit stray done pulses that must be ignored.
  int lat = 3;
  bit noise_en = 1'b0;
  initial begin
    int dcnt;
    bit served;
    dcnt = 0; served = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!div_go) begin
        dcnt = 0; served = 1'b0;
        div_done = noise_en && ($urandom_range(3) == 0);
        div_quotient = $urandom; div_remainder = $urandom;
      end else if (!served) begin
        dcnt++;
        if (dcnt >= lat) begin
          div_done = 1'b1;
          div_quotient = div_left / div_right;
          div_remainder = div_left % div_right;
          served = 1'b1;
        end else div_done = 1'b0;
      end else div_done = 1'b0;
    end
  end

  // Compare process: order/content of results, hold stability, go gap,
  // operand stability while go is high.
  initial begin
    res_t e, ph;
    logic pv_hold, p_go, p_fin;
    logic [WIDTH-1:0] pl, pr;
    pv_hold = 0; p_go = 0; p_fin = 0; pl = '0; pr = '0; ph = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        pv_hold = 0; p_go = 0; p_fin = 0;
      end else begin
        if (pv_hold) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", {out_quotient, out_remainder, out_div_by_zero}, ph);
        end
        if (p_fin) chk("go_gap", div_go, 0);
        if (p_go && div_go) chk("div_operands_stable", {div_left, div_right}, {pl, pr});
        if (div_go) chk("go_nonzero_divisor", (div_right != '0), 1);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("result", {out_quotient, out_remainder, out_div_by_zero}, e);
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_left, in_right));
        pv_hold = out_valid && !out_ready;
        ph = {out_quotient, out_remainder, out_div_by_zero};
        p_go = div_go; pl = div_left; pr = div_right;
        p_fin = div_go && div_done;
      end
    end
  end

  // Offer one request; returns at posedge+1 after it is accepted.
  task automatic push(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_left = l; in_right = r;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_go();
    bit ok;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = div_go;
    end
    if (!ok) chk("go_timeout", 0, 1);
  endtask

  // Called at a negedge; returns at the negedge where out_valid is seen.
  task automatic wait_out(output res_t r);
    bit ok;
    ok = out_valid;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = out_valid;
    end
    if (!ok) chk("out_timeout", 0, 1);
    r = {out_quotient, out_remainder, out_div_by_zero};
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && !out_valid && !div_go && !in_valid;
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    logic [WIDTH-1:0] exp_fq [5];
    logic [WIDTH-1:0] exp_fr [5];
    res_t got [$];
    int n, run, best, first_idx;
    bit saw_go, done_rnd;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_div_go", div_go, 0);
    chk("rst_div_ops", {div_left, div_right}, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", {out_quotient, out_remainder, out_div_by_zero}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Single request with a 33-cycle divider
    lat = 33; out_ready = 1'b1;
    push(100, 7);
    wait_go();
    n = 0;
    while (div_go && n < 200) begin n++; @(negedge clk); end
    chk("single_go_width", n, 33);
    wait_out(r);
    chk("single_q", r.q, 14);
    chk("single_r", r.r, 2);
    chk("single_z", r.z, 0);
    drain();

    // Divide by zero: resolved locally, valid the cycle after the pop
    lat = 3; saw_go = 0; first_idx = -1;
    push(55, 0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (div_go) saw_go = 1;
      if (out_valid && first_idx < 0) begin
        first_idx = i;
        r = {out_quotient, out_remainder, out_div_by_zero};
      end
    end
    chk("dz_no_go", saw_go, 0);
    chk("dz_latency", first_idx, 2);
    chk("dz_q", r.q, 32'hFFFF_FFFF);
    chk("dz_r", r.r, 55);
    chk("dz_z", r.z, 1);
    drain();

    // FIFO full behind a busy divider, then backpressure, then release
    lat = 4; out_ready = 1'b0;
    push(9, 3);
    wait_go();
    @(posedge clk); #1;
    push(10, 4); push(11, 5); push(12, 6); push(13, 7);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    wait_out(r);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_valid || div_go || in_ready) n++;
    end
    chk("backpressure_idle", n, 0);
    exp_fq = '{3, 2, 2, 2, 1};
    exp_fr = '{0, 2, 1, 0, 6};
    got.delete();
    for (int i = 0; i < 1000 && got.size() < 5; i++) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
      @(negedge clk);
      if (out_valid && out_ready) got.push_back({out_quotient, out_remainder, out_div_by_zero});
    end
    chk("full_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      chk("full_order_q", got[i].q, exp_fq[i]);
      chk("full_order_r", got[i].r, exp_fr[i]);
    end
    drain();

    // Back-to-back zero divisors: one result per cycle
    run = 0; best = 0;
    fork
      begin push(1, 0); push(2, 0); push(3, 0); end
      begin
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          if (out_valid) run++; else run = 0;
          if (run > best) best = run;
        end
      end
    join
    chk("zero_b2b_run", best, 3);
    drain();

    // Randomized traffic with stray done pulses and random backpressure
    noise_en = 1'b1; done_rnd = 0;
    fork
      begin
        for (int k = 0; k < 150; k++) begin
          logic [WIDTH-1:0] l, d;
          l = ($urandom_range(1) == 1) ? $urandom : $urandom_range(300);
          case ($urandom_range(4))
            0:       d = '0;
            1:       d = $urandom;
            default: d = $urandom_range(1, 20);
          endcase
          lat = $urandom_range(1, 6);
          push(l, d);
          repeat ($urandom_range(2)) @(posedge clk);
          #1;
        end
        done_rnd = 1;
      end
      begin
        while (!done_rnd) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(3) != 0);
        end
      end
    join
    drain();
    noise_en = 1'b0;
    @(posedge clk); #1;

    // Reset while the divider is busy
    lat = 20;
    push(50, 6); push(60, 5);
    wait_go();
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_go_async", div_go, 0);
    chk("mid_rst_valid", out_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid || div_go) n++;
    end
    chk("post_rst_quiet", n, 0);
    @(posedge clk); #1;
    lat = 3;
    push(100, 9);
    wait_go();
    wait_out(r);
    chk("post_rst_q", r.q, 11);
    chk("post_rst_r", r.r, 1);
    drain();

    chk("model_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
